// File: rtl/uart_tx_serializer.sv
// UART transmit serializer. Pops one FIFO word per frame and sends it on the tx
// line as start, data, optional parity and one or two stop bits, one bit per baud tick.
module uart_tx_serializer #(
  parameter int DATA_W      = 8,
  parameter int FIFO_RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p_BaudSig_i,
  input  logic              p_TxEn_i,
  input  logic              p_BigEnd_i,
  input  logic [2:0]        ParityMode_i,
  input  logic              p_TwoStop_i,
  output logic              n_FifoRe_o,
  input  logic [DATA_W-1:0] FifoData_i,
  input  logic              p_FiFoEmpty_i,
  output logic [5:0]        State_o,
  output logic [3:0]        BitCounter_o,
  output logic [DATA_W-1:0] ShiftData_o,
  output logic              SerialData_o,
  output logic              p_Busy_o,
  output logic              p_FrameDone_o
);

  typedef enum logic [5:0] {
    IDLE   = 6'b000001,
    LOAD   = 6'b000010,
    START  = 6'b000100,
    DATA   = 6'b001000,
    PARITY = 6'b010000,
    STOP   = 6'b100000
  } state_t;

  localparam logic [3:0] LAST_BIT = 4'(DATA_W - 1);
  localparam logic [1:0] RD_LAT   = 2'(FIFO_RD_LAT);

  state_t     state;
  logic [1:0] lat_cnt;
  logic       captured;
  logic       big_end;
  logic [2:0] parity_mode;
  logic       two_stop;
  logic       can_start;
  logic       last_stop;
  logic       load_now;

  // Bit of the word sent at data position idx, honouring the latched bit order.
  function automatic logic pick_bit(input logic [DATA_W-1:0] word,
                                    input logic [3:0]        idx,
                                    input logic              msb_first);
    logic b;
    b = 1'b0;
    for (int k = 0; k < DATA_W; k++) begin
      if (idx == 4'(k)) begin
        b = msb_first ? word[DATA_W-1-k] : word[k];
      end
    end
    return b;
  endfunction

  function automatic logic parity_bit(input logic [DATA_W-1:0] word,
                                      input logic [2:0]        mode);
    logic b;
    case (mode)
      3'd1:    b = ^word;
      3'd2:    b = ~^word;
      3'd3:    b = 1'b1;
      default: b = 1'b0;
    endcase
    return b;
  endfunction

  always_comb begin
    can_start = p_TxEn_i & ~p_FiFoEmpty_i;
    last_stop = ~two_stop | (BitCounter_o != 4'd0);
    load_now  = p_BaudSig_i & can_start &
                ((state == IDLE) | ((state == STOP) & last_stop));
  end

  // Frame config is sampled once, on the edge that issues the FIFO read, so
  // mid-frame changes only take effect on the next frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      big_end     <= 1'b0;
      parity_mode <= 3'd0;
      two_stop    <= 1'b0;
    end else if (load_now) begin
      big_end     <= p_BigEnd_i;
      parity_mode <= (ParityMode_i > 3'd4) ? 3'd0 : ParityMode_i;
      two_stop    <= p_TwoStop_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      lat_cnt       <= 2'd0;
      captured      <= 1'b0;
      BitCounter_o  <= 4'd0;
      ShiftData_o   <= '0;
      SerialData_o  <= 1'b1;
      n_FifoRe_o    <= 1'b1;
      p_FrameDone_o <= 1'b0;
    end else begin
      n_FifoRe_o    <= ~load_now;
      p_FrameDone_o <= 1'b0;
      if (load_now) begin
        lat_cnt  <= 2'd0;
        captured <= 1'b0;
      end
      case (state)
        IDLE: begin
          SerialData_o <= 1'b1;
          BitCounter_o <= 4'd0;
          if (load_now) begin
            state <= LOAD;
          end
        end
        // Baud ticks are ignored until the FIFO word has been captured.
        LOAD: begin
          if (!captured) begin
            if (lat_cnt == RD_LAT) begin
              ShiftData_o <= FifoData_i;
              captured    <= 1'b1;
            end else begin
              lat_cnt <= lat_cnt + 2'd1;
            end
          end else if (p_BaudSig_i) begin
            state        <= START;
            SerialData_o <= 1'b0;
          end
        end
        START: begin
          if (p_BaudSig_i) begin
            state        <= DATA;
            BitCounter_o <= 4'd0;
            SerialData_o <= pick_bit(ShiftData_o, 4'd0, big_end);
          end
        end
        DATA: begin
          if (p_BaudSig_i) begin
            if (BitCounter_o == LAST_BIT) begin
              if (parity_mode != 3'd0) begin
                state        <= PARITY;
                SerialData_o <= parity_bit(ShiftData_o, parity_mode);
              end else begin
                state        <= STOP;
                BitCounter_o <= 4'd0;
                SerialData_o <= 1'b1;
              end
            end else begin
              BitCounter_o <= BitCounter_o + 4'd1;
              SerialData_o <= pick_bit(ShiftData_o, BitCounter_o + 4'd1, big_end);
            end
          end
        end
        PARITY: begin
          if (p_BaudSig_i) begin
            state        <= STOP;
            BitCounter_o <= 4'd0;
            SerialData_o <= 1'b1;
          end
        end
        // A frame ending with more data queued chains straight into LOAD.
        STOP: begin
          SerialData_o <= 1'b1;
          if (p_BaudSig_i) begin
            if (!last_stop) begin
              BitCounter_o <= 4'd1;
            end else begin
              p_FrameDone_o <= 1'b1;
              BitCounter_o  <= 4'd0;
              state         <= load_now ? LOAD : IDLE;
            end
          end
        end
        default: begin
          state        <= IDLE;
          SerialData_o <= 1'b1;
        end
      endcase
    end
  end

  assign State_o  = state;
  assign p_Busy_o = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: an 8-bit/latency-1 instance and a
// 9-bit/latency-2 instance, each fed by a small FIFO model and a shared baud pulse.
module tb_uart_tx_serializer;

  localparam logic [5:0] S_IDLE  = 6'b000001;
  localparam logic [5:0] S_LOAD  = 6'b000010;
  localparam logic [5:0] S_START = 6'b000100;
  localparam logic [5:0] S_DATA  = 6'b001000;
  localparam logic [5:0] S_PAR   = 6'b010000;
  localparam logic [5:0] S_STOP  = 6'b100000;

  typedef struct {
    logic [8:0]  word;
    logic        big;
    logic [2:0]  mode;
    logic        two;
    int          nbits;
    logic [15:0] frame;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       baud = 1'b0;
  logic       ten = 1'b0;
  logic       big = 1'b0;
  logic       two = 1'b0;
  logic [2:0] mode = 3'd0;
  int         div = 0;

  logic       re8, empty8, line8, busy8, done8;
  logic [7:0] fdata8 = 8'hC3;
  logic [5:0] st8;
  logic [3:0] cnt8;
  logic [7:0] sh8;
  logic [7:0] mem8 [32];
  int         wr8 = 0;
  int         rd8 = 0;

  logic       re9, empty9, line9, busy9, done9;
  logic [8:0] fdata9 = 9'h0C3;
  logic [5:0] st9;
  logic [3:0] cnt9;
  logic [8:0] sh9;
  logic [8:0] mem9 [32];
  logic       s1v = 1'b0;
  logic [8:0] s1d = 9'h0;
  int         wr9 = 0;
  int         rd9 = 0;

  logic       sel9 = 1'b0;
  logic       obs_line, obs_re, obs_done, obs_busy;
  logic [5:0] obs_st;
  logic [3:0] obs_cnt;
  logic [8:0] obs_sh;
  int         obs_rd;

  int total = 0;
  int bad   = 0;
  vec_t tbl [7];
  vec_t v9a, v9b, t4a, t4b, t4c;
  logic [8:0] last8 = 9'h0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    div  <= (div == 7) ? 0 : div + 1;
    baud <= (div == 6);
  end

  uart_tx_serializer #(.DATA_W(8), .FIFO_RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .p_BaudSig_i(baud), .p_TxEn_i(ten), .p_BigEnd_i(big),
    .ParityMode_i(mode), .p_TwoStop_i(two), .n_FifoRe_o(re8), .FifoData_i(fdata8),
    .p_FiFoEmpty_i(empty8), .State_o(st8), .BitCounter_o(cnt8), .ShiftData_o(sh8),
    .SerialData_o(line8), .p_Busy_o(busy8), .p_FrameDone_o(done8)
  );

  uart_tx_serializer #(.DATA_W(9), .FIFO_RD_LAT(2)) dut9 (
    .clk(clk), .rst(rst), .p_BaudSig_i(baud), .p_TxEn_i(ten), .p_BigEnd_i(big),
    .ParityMode_i(mode), .p_TwoStop_i(two), .n_FifoRe_o(re9), .FifoData_i(fdata9),
    .p_FiFoEmpty_i(empty9), .State_o(st9), .BitCounter_o(cnt9), .ShiftData_o(sh9),
    .SerialData_o(line9), .p_Busy_o(busy9), .p_FrameDone_o(done9)
  );

  assign empty8 = (rd8 == wr8);
  assign empty9 = (rd9 == wr9);

  // FIFO models: data is valid only for the cycle the DUT should capture it.
  always @(posedge clk) begin
    if (re8 === 1'b0) begin
      fdata8 <= mem8[rd8[4:0]];
      rd8    <= rd8 + 1;
    end else begin
      fdata8 <= 8'hC3;
    end
  end

  always @(posedge clk) begin
    s1v    <= (re9 === 1'b0);
    s1d    <= mem9[rd9[4:0]];
    fdata9 <= s1v ? s1d : 9'h0C3;
    if (re9 === 1'b0) rd9 <= rd9 + 1;
  end

  always_comb begin
    obs_line = sel9 ? line9 : line8;
    obs_re   = sel9 ? re9 : re8;
    obs_done = sel9 ? done9 : done8;
    obs_busy = sel9 ? busy9 : busy8;
    obs_st   = sel9 ? st9 : st8;
    obs_cnt  = sel9 ? cnt9 : cnt8;
    obs_sh   = sel9 ? sh9 : {1'b0, sh8};
    obs_rd   = sel9 ? rd9 : rd8;
  end

  task automatic compare(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tfail(input string nm);
    total++;
    bad++;
    $display("[TB] FAIL %s: got timeout, expected event", nm);
  endtask

  task automatic wait_re(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (obs_re === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (baud === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic push_word(input logic [8:0] w);
    if (sel9) begin
      mem9[wr9[4:0]] = w;
      wr9++;
    end else begin
      mem8[wr8[4:0]] = w[7:0];
      wr8++;
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    push_word(v.word);
    big  = v.big;
    mode = v.mode;
    two  = v.two;
    ten  = 1'b1;
  endtask

  // Follows one frame from its RE pulse to FrameDone; scramble flips the config
  // and drops TxEn partway through the data bits.
  task automatic checkOutput(input string tag, input vec_t v, input int lat,
                             input logic [8:0] prev, input logic [5:0] exp_after,
                             input bit scramble);
    int w, npar, nb, rd0;
    bit ok;
    logic [5:0] es;
    logic [8:0] word;
    w    = sel9 ? 9 : 8;
    word = sel9 ? v.word : {1'b0, v.word[7:0]};
    npar = (v.mode >= 3'd1 && v.mode <= 3'd4) ? 1 : 0;
    nb   = v.nbits;
    wait_re(ok);
    if (!ok) begin
      tfail({tag, "_re"});
      return;
    end
    rd0 = obs_rd;
    compare({tag, "_load_state"}, 32'(obs_st), 32'(S_LOAD));
    compare({tag, "_load_line"}, 32'(obs_line), 32'd1);
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      if (c == 1) compare({tag, "_re_width"}, 32'(obs_re), 32'd1);
      compare($sformatf("%s_capture%0d", tag, c), 32'(obs_sh), 32'((c == lat + 1) ? word : prev));
    end
    for (int i = 0; i < nb; i++) begin
      wait_tick(ok);
      if (!ok) begin
        tfail({tag, "_tick"});
        return;
      end
      compare($sformatf("%s_line%0d", tag, i), 32'(obs_line), 32'(v.frame[nb-1-i]));
      if (i == 0)                         es = S_START;
      else if (i <= w)                    es = S_DATA;
      else if (npar == 1 && i == w + 1)   es = S_PAR;
      else                                es = S_STOP;
      compare($sformatf("%s_state%0d", tag, i), 32'(obs_st), 32'(es));
      if (es == S_DATA) compare($sformatf("%s_bitcnt%0d", tag, i), 32'(obs_cnt), 32'(i - 1));
      if (es == S_STOP) compare($sformatf("%s_stopcnt%0d", tag, i), 32'(obs_cnt),
                                32'((i == nb - 1 && v.two) ? 1 : 0));
      compare($sformatf("%s_busy%0d", tag, i), 32'(obs_busy), 32'd1);
      if (scramble && i == 3) begin
        big  = 1'b1;
        mode = 3'd1;
        two  = 1'b0;
        ten  = 1'b0;
      end
    end
    wait_tick(ok);
    compare({tag, "_done"}, 32'(obs_done), 32'd1);
    compare({tag, "_after_state"}, 32'(obs_st), 32'(exp_after));
    compare({tag, "_gap_line"}, 32'(obs_line), 32'd1);
    compare({tag, "_re_count"}, 32'(obs_rd), 32'(rd0 + 1));
    if (exp_after == S_IDLE) begin
      @(negedge clk);
      compare({tag, "_done_width"}, 32'(obs_done), 32'd0);
      compare({tag, "_idle_re"}, 32'(obs_re), 32'd1);
      compare({tag, "_idle_busy"}, 32'(obs_busy), 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit ok;
    int r;
    tbl[0] = '{9'h0A5, 1'b0, 3'd0, 1'b0, 10, 16'b000000_0_10100101_1};
    tbl[1] = '{9'h007, 1'b1, 3'd1, 1'b0, 11, 16'b00000_0_00000111_1_1};
    tbl[2] = '{9'h007, 1'b1, 3'd2, 1'b0, 11, 16'b00000_0_00000111_0_1};
    tbl[3] = '{9'h03C, 1'b0, 3'd4, 1'b1, 12, 16'b0000_0_00111100_0_11};
    tbl[4] = '{9'h080, 1'b0, 3'd3, 1'b0, 11, 16'b00000_0_00000001_1_1};
    tbl[5] = '{9'h05A, 1'b1, 3'd6, 1'b1, 11, 16'b00000_0_01011010_11};
    tbl[6] = '{9'h0B3, 1'b0, 3'd2, 1'b0, 11, 16'b00000_0_11001101_0_1};
    v9a    = '{9'h1FF, 1'b0, 3'd3, 1'b1, 13, 16'b000_0_111111111_1_11};
    v9b    = '{9'h0B5, 1'b1, 3'd1, 1'b0, 12, 16'b0000_0_010110101_1_1};
    t4a    = '{9'h011, 1'b0, 3'd0, 1'b0, 10, 16'b000000_0_10001000_1};
    t4b    = '{9'h022, 1'b0, 3'd0, 1'b0, 10, 16'b000000_0_01000100_1};
    t4c    = '{9'h033, 1'b0, 3'd0, 1'b0, 10, 16'b000000_0_11001100_1};

    #2 rst = 1'b0;
    #1;
    compare("rst_state", 32'(st8), 32'(S_IDLE));
    compare("rst_line", 32'(line8), 32'd1);
    compare("rst_re", 32'(re8), 32'd1);
    compare("rst_cnt", 32'(cnt8), 32'd0);
    compare("rst_shift", 32'(sh8), 32'd0);
    compare("rst_done", 32'(done8), 32'd0);
    compare("rst_busy", 32'(busy8), 32'd0);
    compare("rst_state9", 32'(st9), 32'(S_IDLE));
    repeat (4) @(negedge clk);
    rst = 1'b1;
    ten = 1'b1;
    repeat (2) wait_tick(ok);
    compare("empty_no_re", 32'(rd8), 32'd0);
    compare("empty_state", 32'(st8), 32'(S_IDLE));
    compare("empty_line", 32'(line8), 32'd1);

    $display("[TB] table-driven single frames");
    for (int k = 0; k < 7; k++) begin
      applyStimulus(tbl[k]);
      checkOutput($sformatf("v%0d", k), tbl[k], 1, last8, S_IDLE, 1'b0);
      last8 = tbl[k].word;
    end

    $display("[TB] back-to-back frames");
    @(negedge clk);
    push_word(t4a.word);
    push_word(t4b.word);
    push_word(t4c.word);
    big = 1'b0; mode = 3'd0; two = 1'b0; ten = 1'b1;
    r = rd8;
    checkOutput("b2b0", t4a, 1, last8, S_LOAD, 1'b0);
    checkOutput("b2b1", t4b, 1, t4a.word, S_LOAD, 1'b0);
    checkOutput("b2b2", t4c, 1, t4b.word, S_IDLE, 1'b0);
    compare("b2b_re_total", 32'(rd8), 32'(r + 3));
    last8 = t4c.word;

    $display("[TB] mid-frame config change and TxEn drop");
    applyStimulus(tbl[0]);
    push_word(tbl[1].word);
    checkOutput("cfg0", tbl[0], 1, last8, S_IDLE, 1'b1);
    r = rd8;
    repeat (3) wait_tick(ok);
    compare("cfg_hold_re", 32'(rd8), 32'(r));
    compare("cfg_hold_state", 32'(st8), 32'(S_IDLE));
    compare("cfg_hold_line", 32'(line8), 32'd1);
    ten = 1'b1;
    checkOutput("cfg1", tbl[1], 1, tbl[0].word, S_IDLE, 1'b0);
    last8 = tbl[1].word;

    $display("[TB] reset mid-frame");
    applyStimulus(tbl[3]);
    wait_re(ok);
    if (!ok) tfail("rstmid_re");
    repeat (4) wait_tick(ok);
    compare("rstmid_pre_state", 32'(st8), 32'(S_DATA));
    #2 rst = 1'b0;
    #1;
    compare("rstmid_state", 32'(st8), 32'(S_IDLE));
    compare("rstmid_line", 32'(line8), 32'd1);
    compare("rstmid_cnt", 32'(cnt8), 32'd0);
    compare("rstmid_shift", 32'(sh8), 32'd0);
    compare("rstmid_re", 32'(re8), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    r = rd8;
    repeat (3) wait_tick(ok);
    compare("rstmid_no_re", 32'(rd8), 32'(r));
    compare("rstmid_idle", 32'(st8), 32'(S_IDLE));
    compare("rstmid_idle_line", 32'(line8), 32'd1);

    $display("[TB] 9-bit, read latency 2");
    sel9 = 1'b1;
    applyStimulus(v9a);
    checkOutput("w9a", v9a, 2, 9'h000, S_IDLE, 1'b0);
    applyStimulus(v9b);
    checkOutput("w9b", v9b, 2, v9a.word, S_IDLE, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
